// File: rtl/param_datapath.sv
// Single-bus CPU datapath: register file, special registers, encoded bus mux, ALU and an
// iterative signed Booth multiplier / non-restoring divider that delivers its result into Z.
module param_datapath #(
    parameter int W       = 32,
    parameter int NREGS   = 16,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic         clock,
    input  logic         clear,
    input  logic [4:0]   bus_src,
    input  logic         reg_we,
    input  logic [3:0]   reg_idx,
    input  logic         HIin,
    input  logic         LOin,
    input  logic         PCin,
    input  logic         IRin,
    input  logic         Yin,
    input  logic         MARin,
    input  logic         MDRin,
    input  logic         Zin,
    input  logic         Read,
    input  logic         IncPC,
    input  logic [4:0]   alu_op,
    input  logic [W-1:0] mdata_in,
    input  logic [W-1:0] inport_in,
    input  logic [W-1:0] csign_in,
    output logic [W-1:0] bus_out,
    output logic [W-1:0] mar_out,
    output logic [W-1:0] ir_out,
    output logic [W-1:0] pc_out,
    output logic         busy,
    output logic         done,
    output logic         div0
);
    localparam int SW = $clog2(W);
    localparam logic [SW-1:0] LAST = SW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DZERO} SeqState;

    SeqState state, nextState;

    logic [W-1:0]   regFile [NREGS];
    logic [W-1:0]   hi, lo, pc, ir, mar, mdr, y, inportReg;
    logic [2*W-1:0] z;
    logic [W-1:0]   busVal, aluResult;
    logic [SW-1:0]  shAmt, negAmt;

    logic           opIsDiv, quotNeg, remNeg, qm1;
    logic [SW-1:0]  iterCnt;
    logic [W+1:0]   acc, mExt, boothSum, divShift, divSum, accNext;
    logic [W-1:0]   qReg, mReg, qNext, divRem, quotient, remainder;
    logic           zAccept, startSeq, lastIter, seqFinish;

    // Encoded bus mux; unused codes and absent registers read as zero.
    always_comb begin
        busVal = '0;
        case (bus_src)
            5'd16: busVal = hi;
            5'd17: busVal = lo;
            5'd18: busVal = z[2*W-1:W];
            5'd19: busVal = z[W-1:0];
            5'd20: busVal = pc;
            5'd21: busVal = mdr;
            5'd22: busVal = inportReg;
            5'd23: busVal = csign_in;
            default: begin
                if (!bus_src[4]) begin
                    for (int i = 0; i < NREGS; i++) begin
                        if (bus_src[3:0] == 4'(i) && !(R0_ZERO && i == 0)) busVal = regFile[i];
                    end
                end
            end
        endcase
    end

    assign bus_out = busVal;
    assign mar_out = mar;
    assign ir_out  = ir;
    assign pc_out  = pc;

    // Rotate by the complementary amount modulo W, which degenerates cleanly when the amount is zero.
    assign shAmt  = busVal[SW-1:0];
    assign negAmt = -shAmt;

    always_comb begin
        aluResult = '0;
        case (alu_op)
            5'd0:    aluResult = y + busVal;
            5'd1:    aluResult = y - busVal;
            5'd2:    aluResult = y & busVal;
            5'd3:    aluResult = y | busVal;
            5'd4:    aluResult = y >> shAmt;
            5'd5:    aluResult = $signed(y) >>> shAmt;
            5'd6:    aluResult = y << shAmt;
            5'd7:    aluResult = (y >> shAmt) | (y << negAmt);
            5'd8:    aluResult = (y << shAmt) | (y >> negAmt);
            5'd9:    aluResult = -busVal;
            5'd10:   aluResult = ~busVal;
            default: aluResult = '0;
        endcase
    end

    // Divide works on magnitudes, so the divisor is zero-extended; Booth needs it sign-extended.
    assign mExt = opIsDiv ? {2'b00, mReg} : {{2{mReg[W-1]}}, mReg};

    always_comb begin
        case ({qReg[0], qm1})
            2'b01:   boothSum = acc + mExt;
            2'b10:   boothSum = acc - mExt;
            default: boothSum = acc;
        endcase
    end

    assign divShift = {acc[W:0], qReg[W-1]};
    assign divSum   = acc[W+1] ? divShift + mExt : divShift - mExt;
    assign divRem   = divSum[W+1] ? divSum[W-1:0] + mReg : divSum[W-1:0];

    always_comb begin
        if (opIsDiv) begin
            accNext = divSum;
            qNext   = {qReg[W-2:0], ~divSum[W+1]};
        end else begin
            accNext = {boothSum[W+1], boothSum[W+1:1]};
            qNext   = {boothSum[0], qReg[W-1:1]};
        end
    end

    assign quotient  = quotNeg ? -qNext : qNext;
    assign remainder = remNeg ? -divRem : divRem;

    assign zAccept  = Zin && (state == IDLE);
    assign startSeq = zAccept && !IncPC && (alu_op == 5'd11 || alu_op == 5'd12);
    assign lastIter = (state == RUN) && (iterCnt == LAST);

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startSeq) nextState = (alu_op == 5'd12 && busVal == '0) ? DZERO : RUN;
            RUN:     if (iterCnt == LAST) nextState = IDLE;
            DZERO:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        seqFinish = lastIter || (state == DZERO);
    end

    // Register loads and the sequencer datapath; operands are captured at start so later bus/Y changes are harmless.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
            hi        <= '0;
            lo        <= '0;
            pc        <= '0;
            ir        <= '0;
            mar       <= '0;
            mdr       <= '0;
            y         <= '0;
            inportReg <= '0;
            z         <= '0;
            done      <= 1'b0;
            div0      <= 1'b0;
            opIsDiv   <= 1'b0;
            quotNeg   <= 1'b0;
            remNeg    <= 1'b0;
            qm1       <= 1'b0;
            iterCnt   <= '0;
            acc       <= '0;
            qReg      <= '0;
            mReg      <= '0;
        end else begin
            if (reg_we) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (reg_idx == 4'(i) && !(R0_ZERO && i == 0)) regFile[i] <= busVal;
                end
            end
            if (HIin)  hi  <= busVal;
            if (LOin)  lo  <= busVal;
            if (PCin)  pc  <= busVal;
            if (IRin)  ir  <= busVal;
            if (Yin)   y   <= busVal;
            if (MARin) mar <= busVal;
            if (MDRin) mdr <= Read ? mdata_in : busVal;
            inportReg <= inport_in;
            done      <= seqFinish;

            if (startSeq) begin
                opIsDiv <= (alu_op == 5'd12);
                iterCnt <= '0;
                acc     <= '0;
                qm1     <= 1'b0;
                quotNeg <= y[W-1] ^ busVal[W-1];
                remNeg  <= y[W-1];
                if (alu_op == 5'd12) begin
                    div0 <= 1'b0;
                    qReg <= (busVal == '0 || !y[W-1]) ? y : -y;
                    mReg <= busVal[W-1] ? -busVal : busVal;
                end else begin
                    qReg <= y;
                    mReg <= busVal;
                end
            end else if (zAccept) begin
                z <= IncPC ? {{W{1'b0}}, busVal + W'(1)} : {{W{1'b0}}, aluResult};
            end else if (state == RUN) begin
                acc     <= accNext;
                qReg    <= qNext;
                qm1     <= qReg[0];
                iterCnt <= iterCnt + SW'(1);
                if (lastIter) z <= opIsDiv ? {remainder, quotient} : {accNext[W-1:0], qNext};
            end else if (state == DZERO) begin
                z    <= {qReg, {W{1'b1}}};
                div0 <= 1'b1;
            end
        end
    end
endmodule
